// File: rtl/reservation_station_mc_if.sv
// ---------------------------------------------------------------------------
// reservation_station_mc_if
//
// Bundles every signal of reservation_station_mc except clk_in/rst_in.
//
// master modport : dispatcher / CDB / arbiter side (drives the strobes,
//                  operands and RS_update_ready, observes results and flags)
// slave modport  : the reservation station itself
//
// Signal groups:
//   rdy_in                      global run enable (0 freezes all state)
//   new_entry_*                 dispatch strobe and entry payload
//   rob_head                    RoB head used for age ordering
//   CDB_update_en/index/data    packed per-port broadcast snoop
//   RS_update_valid/ready/...   registered result output
//   flush_signal                misprediction flush
//   isFull/isEmpty/count        occupancy from registered busy bits
//
// Result handshake: a result transfers on a rising clock edge where
// RS_update_valid and RS_update_ready are both 1. While RS_update_valid=1 and
// RS_update_ready=0 the index and data are held unchanged. The station never
// withdraws a valid result except through flush or reset.
// ---------------------------------------------------------------------------
interface reservation_station_mc_if #(
    parameter int RS_WIDTH  = 3,
    parameter int RoB_WIDTH = 3,
    parameter int CDB_PORTS = 2
);
    logic                          rdy_in;
    logic                          new_entry_en;
    logic [RoB_WIDTH-1:0]          new_entry_robEntry;
    logic [6:0]                    new_entry_opcode;
    logic [31:0]                   new_entry_Vj;
    logic [31:0]                   new_entry_Vk;
    logic [31:0]                   new_entry_imm;
    logic [31:0]                   new_entry_pc;
    logic [RoB_WIDTH:0]            new_entry_Qj;
    logic [RoB_WIDTH:0]            new_entry_Qk;
    logic [RoB_WIDTH-1:0]          rob_head;
    logic [CDB_PORTS-1:0]          CDB_update_en;
    logic [CDB_PORTS*RoB_WIDTH-1:0] CDB_update_index;
    logic [CDB_PORTS*32-1:0]       CDB_update_data;
    logic                          RS_update_valid;
    logic                          RS_update_ready;
    logic [RoB_WIDTH-1:0]          RS_update_index;
    logic [31:0]                   RS_update_data;
    logic                          flush_signal;
    logic                          isFull;
    logic                          isEmpty;
    logic [RS_WIDTH:0]             count;

    modport master (
        output rdy_in, new_entry_en, new_entry_robEntry, new_entry_opcode,
               new_entry_Vj, new_entry_Vk, new_entry_imm, new_entry_pc,
               new_entry_Qj, new_entry_Qk, rob_head,
               CDB_update_en, CDB_update_index, CDB_update_data,
               RS_update_ready, flush_signal,
        input  RS_update_valid, RS_update_index, RS_update_data,
               isFull, isEmpty, count
    );

    modport slave (
        input  rdy_in, new_entry_en, new_entry_robEntry, new_entry_opcode,
               new_entry_Vj, new_entry_Vk, new_entry_imm, new_entry_pc,
               new_entry_Qj, new_entry_Qk, rob_head,
               CDB_update_en, CDB_update_index, CDB_update_data,
               RS_update_ready, flush_signal,
        output RS_update_valid, RS_update_index, RS_update_data,
               isFull, isEmpty, count
    );
endinterface

// File: rtl/reservation_station_mc.sv
// ---------------------------------------------------------------------------
// reservation_station_mc
//
// Integer reservation station snooping CDB_PORTS broadcast ports. Buffers
// ALU / branch / jalr ops until both operands are resolved, issues the oldest
// ready entry (age = robEntry - rob_head, mod RoB size, ties to lowest slot),
// computes the result in-block and holds it in a valid/ready output register.
//
// Ports:
//   clk_in  clock
//   rst_in  asynchronous active-low reset
//   bus     reservation_station_mc_if.slave (dispatch, CDB snoop, result
//           handshake, flush, rdy_in and occupancy flags)
//
// Optional feature (macro RS_WAKEUP_BYPASS_EN): when defined, readiness also
// counts this cycle's CDB matches, so an entry whose last operand is broadcast
// in cycle N issues at edge N using the broadcast data.
// ---------------------------------------------------------------------------
module reservation_station_mc #(
    parameter int RS_WIDTH  = 3,
    parameter int RoB_WIDTH = 3,
    parameter int CDB_PORTS = 2
) (
    input logic                    clk_in,
    input logic                    rst_in,
    reservation_station_mc_if.slave bus
);
    localparam int RS_SIZE = 1 << RS_WIDTH;
    localparam int CW      = RS_WIDTH + 1;
    // Tag with the extra MSB set: cannot match any CDB index.
    localparam logic [RoB_WIDTH:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};

    localparam logic [6:0] OP_JALR  = 7'd4,  OP_BEQ  = 7'd5,  OP_BNE  = 7'd6;
    localparam logic [6:0] OP_BLT   = 7'd7,  OP_BGE  = 7'd8,  OP_BLTU = 7'd9;
    localparam logic [6:0] OP_BGEU  = 7'd10, OP_ADDI = 7'd19, OP_SLTI = 7'd20;
    localparam logic [6:0] OP_SLTIU = 7'd21, OP_XORI = 7'd22, OP_ORI  = 7'd23;
    localparam logic [6:0] OP_ANDI  = 7'd24, OP_SLLI = 7'd25, OP_SRLI = 7'd26;
    localparam logic [6:0] OP_SRAI  = 7'd27, OP_ADD  = 7'd28, OP_SUB  = 7'd29;
    localparam logic [6:0] OP_SLL   = 7'd30, OP_SLT  = 7'd31, OP_SLTU = 7'd32;
    localparam logic [6:0] OP_XOR   = 7'd33, OP_SRL  = 7'd34, OP_SRA  = 7'd35;
    localparam logic [6:0] OP_OR    = 7'd36, OP_AND  = 7'd37;

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } snoop_t;

    // Lowest-numbered active port whose index equals the tag.
    function automatic snoop_t snoop(
        input logic [RoB_WIDTH:0]           tag,
        input logic [CDB_PORTS-1:0]         en,
        input logic [CDB_PORTS*RoB_WIDTH-1:0] idx,
        input logic [CDB_PORTS*32-1:0]      data
    );
        snoop_t r;
        r = '0;
        // Walk downward so the lowest matching port is written last.
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (en[p] && (tag == {1'b0, idx[p*RoB_WIDTH +: RoB_WIDTH]})) begin
                r.hit  = 1'b1;
                r.data = data[p*32 +: 32];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] alu(
        input logic [6:0]  op,
        input logic [31:0] vj,
        input logic [31:0] vk,
        input logic [31:0] imm,
        input logic [31:0] pc
    );
        logic [31:0] tgt;
        logic [31:0] seq;
        logic [31:0] r;
        tgt = pc + imm;
        seq = pc + 32'd4;
        case (op)
            OP_JALR:  r = (vj + imm) & ~32'd1;
            OP_BEQ:   r = (vj == vk) ? tgt : seq;
            OP_BNE:   r = (vj != vk) ? tgt : seq;
            OP_BLT:   r = ($signed(vj) <  $signed(vk)) ? tgt : seq;
            OP_BGE:   r = ($signed(vj) >= $signed(vk)) ? tgt : seq;
            OP_BLTU:  r = (vj <  vk) ? tgt : seq;
            OP_BGEU:  r = (vj >= vk) ? tgt : seq;
            OP_ADDI:  r = vj + imm;
            OP_SLTI:  r = {31'd0, ($signed(vj) < $signed(imm))};
            OP_SLTIU: r = {31'd0, (vj < imm)};
            OP_XORI:  r = vj ^ imm;
            OP_ORI:   r = vj | imm;
            OP_ANDI:  r = vj & imm;
            OP_SLLI:  r = vj << imm[4:0];
            OP_SRLI:  r = vj >> imm[4:0];
            OP_SRAI:  r = $signed(vj) >>> imm[4:0];
            OP_ADD:   r = vj + vk;
            OP_SUB:   r = vj - vk;
            OP_SLL:   r = vj << vk[4:0];
            OP_SLT:   r = {31'd0, ($signed(vj) < $signed(vk))};
            OP_SLTU:  r = {31'd0, (vj < vk)};
            OP_XOR:   r = vj ^ vk;
            OP_SRL:   r = vj >> vk[4:0];
            OP_SRA:   r = $signed(vj) >>> vk[4:0];
            OP_OR:    r = vj | vk;
            OP_AND:   r = vj & vk;
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

    // Entry storage
    logic [RS_SIZE-1:0]   busy_q, busy_d;
    logic [RoB_WIDTH-1:0] rob_q [RS_SIZE];
    logic [RoB_WIDTH-1:0] rob_d [RS_SIZE];
    logic [6:0]           op_q  [RS_SIZE];
    logic [6:0]           op_d  [RS_SIZE];
    logic [31:0]          vj_q  [RS_SIZE];
    logic [31:0]          vj_d  [RS_SIZE];
    logic [31:0]          vk_q  [RS_SIZE];
    logic [31:0]          vk_d  [RS_SIZE];
    logic [31:0]          imm_q [RS_SIZE];
    logic [31:0]          imm_d [RS_SIZE];
    logic [31:0]          pc_q  [RS_SIZE];
    logic [31:0]          pc_d  [RS_SIZE];
    logic [RoB_WIDTH:0]   qj_q  [RS_SIZE];
    logic [RoB_WIDTH:0]   qj_d  [RS_SIZE];
    logic [RoB_WIDTH:0]   qk_q  [RS_SIZE];
    logic [RoB_WIDTH:0]   qk_d  [RS_SIZE];

    // Output register
    logic                 valid_q, valid_d;
    logic [RoB_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]          data_q, data_d;

    // Post-wakeup view of each entry's operands
    logic [RoB_WIDTH:0]   qj_w [RS_SIZE];
    logic [RoB_WIDTH:0]   qk_w [RS_SIZE];
    logic [31:0]          vj_w [RS_SIZE];
    logic [31:0]          vk_w [RS_SIZE];
    // Operands and readiness seen by the issue logic
    logic [31:0]          opj  [RS_SIZE];
    logic [31:0]          opk  [RS_SIZE];
    logic [RS_SIZE-1:0]   ready_vec;

    logic                 sel_found;
    logic [RS_WIDTH-1:0]  sel_idx;
    logic [RoB_WIDTH-1:0] sel_age;
    logic                 free_found;
    logic [RS_WIDTH-1:0]  free_idx;
    logic [CW-1:0]        cnt;
    logic                 is_full;
    logic                 issue;
    logic                 dispatch_ok;
    logic [31:0]          alu_result;
    snoop_t               new_j, new_k;

    always_comb begin
        snoop_t sj;
        snoop_t sk;
        sj = '0;
        sk = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            sj = snoop(qj_q[i], bus.CDB_update_en, bus.CDB_update_index, bus.CDB_update_data);
            sk = snoop(qk_q[i], bus.CDB_update_en, bus.CDB_update_index, bus.CDB_update_data);
            qj_w[i] = qj_q[i];
            vj_w[i] = vj_q[i];
            qk_w[i] = qk_q[i];
            vk_w[i] = vk_q[i];
            if (busy_q[i] && sj.hit) begin
                qj_w[i] = NON_DEP;
                vj_w[i] = sj.data;
            end
            if (busy_q[i] && sk.hit) begin
                qk_w[i] = NON_DEP;
                vk_w[i] = sk.data;
            end
`ifdef RS_WAKEUP_BYPASS_EN
            ready_vec[i] = busy_q[i] && (qj_w[i] == NON_DEP) && (qk_w[i] == NON_DEP);
            opj[i]       = vj_w[i];
            opk[i]       = vk_w[i];
`else
            ready_vec[i] = busy_q[i] && (qj_q[i] == NON_DEP) && (qk_q[i] == NON_DEP);
            opj[i]       = vj_q[i];
            opk[i]       = vk_q[i];
`endif
        end
    end

    // Oldest ready entry; strict '<' keeps the lowest slot on equal age.
    always_comb begin
        logic [RoB_WIDTH-1:0] age;
        age       = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            age = rob_q[i] - bus.rob_head;
            if (ready_vec[i] && (!sel_found || (age < sel_age))) begin
                sel_found = 1'b1;
                sel_idx   = RS_WIDTH'(i);
                sel_age   = age;
            end
        end
    end

    // Lowest idle slot and occupancy, both from registered busy bits.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        cnt        = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            cnt = cnt + CW'(busy_q[i]);
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = RS_WIDTH'(i);
            end
        end
    end

    assign is_full     = (cnt == CW'(RS_SIZE));
    assign issue       = sel_found && (!valid_q || bus.RS_update_ready);
    assign dispatch_ok = bus.new_entry_en && !is_full && free_found;
    assign alu_result  = alu(op_q[sel_idx], opj[sel_idx], opk[sel_idx],
                             imm_q[sel_idx], pc_q[sel_idx]);
    assign new_j = snoop(bus.new_entry_Qj, bus.CDB_update_en, bus.CDB_update_index, bus.CDB_update_data);
    assign new_k = snoop(bus.new_entry_Qk, bus.CDB_update_en, bus.CDB_update_index, bus.CDB_update_data);

    always_comb begin
        busy_d  = busy_q;
        rob_d   = rob_q;
        op_d    = op_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (bus.flush_signal) begin
            // Dispatch, wakeup and issue in this cycle are all discarded.
            busy_d  = '0;
            valid_d = 1'b0;
            for (int i = 0; i < RS_SIZE; i++) begin
                qj_d[i] = NON_DEP;
                qk_d[i] = NON_DEP;
            end
        end else begin
            qj_d = qj_w;
            qk_d = qk_w;
            vj_d = vj_w;
            vk_d = vk_w;
            if (issue) begin
                busy_d[sel_idx] = 1'b0;
                valid_d         = 1'b1;
                idx_d           = rob_q[sel_idx];
                data_d          = alu_result;
            end else if (valid_q && bus.RS_update_ready) begin
                valid_d = 1'b0;
            end
            // free_idx comes from busy_q, so a slot freed by this cycle's
            // issue is never chosen here.
            if (dispatch_ok) begin
                busy_d[free_idx] = 1'b1;
                rob_d[free_idx]  = bus.new_entry_robEntry;
                op_d[free_idx]   = bus.new_entry_opcode;
                imm_d[free_idx]  = bus.new_entry_imm;
                pc_d[free_idx]   = bus.new_entry_pc;
                qj_d[free_idx]   = new_j.hit ? NON_DEP : bus.new_entry_Qj;
                vj_d[free_idx]   = new_j.hit ? new_j.data : bus.new_entry_Vj;
                qk_d[free_idx]   = new_k.hit ? NON_DEP : bus.new_entry_Qk;
                vk_d[free_idx]   = new_k.hit ? new_k.data : bus.new_entry_Vk;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                rob_q[i] <= '0;
                op_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
                qj_q[i]  <= NON_DEP;
                qk_q[i]  <= NON_DEP;
            end
        end else if (bus.rdy_in) begin
            busy_q  <= busy_d;
            rob_q   <= rob_d;
            op_q    <= op_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            qj_q    <= qj_d;
            qk_q    <= qk_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign bus.RS_update_valid = valid_q;
    assign bus.RS_update_index = idx_q;
    assign bus.RS_update_data  = data_q;
    assign bus.count           = cnt;
    assign bus.isFull          = is_full;
    assign bus.isEmpty         = (cnt == '0);
endmodule
